// File: rtl/oram_writer_pkg.sv
// oram_writer_pkg: shared constants and write-engine state encoding for oram_writer.
//   ADDRESS_WIDTH : default output RAM word-address width
//   OW_SMNL       : width of the write-engine state register
//   ow_state_t    : OW_IDLE / OW_WRITE / OW_DONE
package oram_writer_pkg;
   localparam int ADDRESS_WIDTH = 12;
   localparam int OW_SMNL = 2;
   typedef enum logic [OW_SMNL-1:0] {
      OW_IDLE  = 2'd0,
      OW_WRITE = 2'd1,
      OW_DONE  = 2'd2
   } ow_state_t;
endpackage

// File: rtl/oram_writer_sync_fifo.sv
// sync_fifo: DEPTH x W synchronous FIFO with registered count and combinational head.
//   clk, reset (sync, active-low) | push, wdata : write side
//   pop, head : read side (head valid while !empty)
//   count, full, empty : occupancy
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp, rp;
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
   // storage is not reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wdata;
   end
   assign head  = mem[rp];
   assign full  = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/oram_writer.sv
// oram_writer: buffers the core's ARM instruction stream and writes it sequentially to the output RAM.
//   clk, reset (sync, active-low)
//   arm_inst, valid_write, oram_ready : input stream from the core with back-pressure
//   flush : end-of-translation pulse
//   mem_we, mem_addr, mem_wdata, mem_ack : output RAM request/acknowledge port
//   word_count, done, overflow : status
module oram_writer
   import oram_writer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ADDR_W = ADDRESS_WIDTH,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       arm_inst,
   input  logic              valid_write,
   output logic              oram_ready,
   input  logic              flush,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              overflow
);
   localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};
   ow_state_t state, state_n;
   logic flush_pending, push, pop, ack, fin, full, empty;
   logic [31:0] head;
   logic [$clog2(DEPTH):0] count;
   // ready depends only on registers so the core's valid_write may depend on it
   assign oram_ready = !full && state != OW_DONE;
   assign push = valid_write && oram_ready;
   // after overflow the head is discarded one entry per cycle without a request
   assign pop = state == OW_WRITE && (mem_ack || overflow);
   assign ack = mem_we && mem_ack;
   // a flush arriving this cycle counts, so done follows the pulse by one cycle
   assign fin = flush_pending || flush;
   assign mem_we = state == OW_WRITE && !overflow;
   assign mem_wdata = state == OW_WRITE ? head : '0;
   assign done = state == OW_DONE;
   sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .wdata(arm_inst), .pop(pop),
      .head(head), .count(count), .full(full), .empty(empty)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= OW_IDLE;
         flush_pending <= 1'b0;
         overflow <= 1'b0;
         mem_addr <= BASE_ADDR;
         word_count <= '0;
      end else begin
         state <= state_n;
         if (flush) flush_pending <= 1'b1;
         if (ack) begin
            mem_addr <= mem_addr + 1'b1;
            if (&mem_addr) overflow <= 1'b1;
            if (word_count != WC_MAX) word_count <= word_count + 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         OW_IDLE:  state_n = (push || !empty) ? OW_WRITE : fin ? OW_DONE : OW_IDLE;
         OW_WRITE: state_n = (!pop || push || count > 1) ? OW_WRITE : fin ? OW_DONE : OW_IDLE;
         default:  state_n = OW_DONE;
      endcase
   end
endmodule

// File: tb/tb_oram_writer.sv
// tb_oram_writer: randomized self-checking bench for oram_writer (default and ADDR_W=3 instances).
module tb_oram_writer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] arm_inst = '0;
   logic valid_write = 1'b0;
   logic flush = 1'b0;
   logic mem_ack = 1'b0;
   logic rdy0, rdy1, we0, we1, dn0, dn1, ov0, ov1;
   logic [11:0] addr0;
   logic [2:0] addr1;
   logic [31:0] wd0, wd1;
   logic [12:0] wc0;
   logic [3:0] wc1;
   int checks = 0;
   int errors = 0;
   // transaction-level reference model, one per instance
   logic [31:0] mq [2][256];
   int rd [2];
   int wr [2];
   int na [2];
   bit ovf_m [2];
   bit pend [2];
   bit dn_m [2];
   int mod_m [2] = '{4096, 8};
   int writes1 = 0;

   always #5 clk = ~clk;

   oram_writer u_dflt (
      .clk(clk), .reset(reset), .arm_inst(arm_inst), .valid_write(valid_write),
      .oram_ready(rdy0), .flush(flush), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wd0), .mem_ack(mem_ack), .word_count(wc0), .done(dn0), .overflow(ov0)
   );
   oram_writer #(.ADDR_W(3)) u_small (
      .clk(clk), .reset(reset), .arm_inst(arm_inst), .valid_write(valid_write),
      .oram_ready(rdy1), .flush(flush), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wd1), .mem_ack(mem_ack), .word_count(wc1), .done(dn1), .overflow(ov1)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // one clock: model the edge from the current inputs, then compare at the falling edge
   task automatic tick();
      bit acc [2];
      for (int i = 0; i < 2; i++) acc[i] = valid_write && (wr[i] - rd[i] < 8) && !dn_m[i];
      if (we1 && mem_ack) writes1++;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            rd[i] = 0; wr[i] = 0; na[i] = 0;
            ovf_m[i] = 0; pend[i] = 0; dn_m[i] = 0;
         end else begin
            if (wr[i] > rd[i] && (ovf_m[i] || mem_ack)) begin
               if (!ovf_m[i]) begin
                  if (na[i] % mod_m[i] == mod_m[i] - 1) ovf_m[i] = 1;
                  na[i]++;
               end
               rd[i]++;
            end
            if (acc[i]) begin
               mq[i][wr[i] % 256] = arm_inst;
               wr[i]++;
            end
            if (flush) pend[i] = 1;
            if (wr[i] == rd[i] && pend[i]) dn_m[i] = 1;
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d.oram_ready", i), 32'(i == 0 ? rdy0 : rdy1), 32'(wr[i] - rd[i] < 8 && !dn_m[i]));
         check($sformatf("u%0d.mem_we", i), 32'(i == 0 ? we0 : we1), 32'(wr[i] > rd[i] && !ovf_m[i]));
         check($sformatf("u%0d.mem_addr", i), i == 0 ? 32'(addr0) : 32'(addr1), 32'(na[i] % mod_m[i]));
         check($sformatf("u%0d.word_count", i), i == 0 ? 32'(wc0) : 32'(wc1), 32'(na[i]));
         check($sformatf("u%0d.done", i), 32'(i == 0 ? dn0 : dn1), 32'(dn_m[i]));
         check($sformatf("u%0d.overflow", i), 32'(i == 0 ? ov0 : ov1), 32'(ovf_m[i]));
         if (wr[i] > rd[i] && !ovf_m[i])
            check($sformatf("u%0d.mem_wdata", i), i == 0 ? wd0 : wd1, mq[i][rd[i] % 256]);
      end
   endtask

   initial begin
      @(negedge clk);
      tick();
      tick();
      check("rst_wdata", wd0, 32'h0);
      check("rst_we", 32'(we0), 32'h0);
      reset = 1'b1;
      // two back-to-back words with ack tied high
      mem_ack = 1'b1;
      valid_write = 1'b1;
      arm_inst = 32'hE3400001;
      tick();
      check("t1_addr0", 32'(addr0), 32'h0);
      check("t1_data0", wd0, 32'hE3400001);
      arm_inst = 32'hE52D0004;
      tick();
      check("t1_addr1", 32'(addr0), 32'h1);
      check("t1_data1", wd0, 32'hE52D0004);
      valid_write = 1'b0;
      tick();
      tick();
      check("t1_count", 32'(wc0), 32'd2);
      // fill under a stall: the ninth word must be refused
      mem_ack = 1'b0;
      valid_write = 1'b1;
      for (int k = 0; k < 9; k++) begin
         arm_inst = $urandom;
         tick();
      end
      valid_write = 1'b0;
      check("full_ready", 32'(rdy0), 32'h0);
      mem_ack = 1'b1;
      repeat (10) tick();
      check("drain_count", 32'(wc0), 32'd10);
      // random traffic with random ack stalls
      repeat (300) begin
         valid_write = 1'($urandom % 2);
         arm_inst = $urandom;
         mem_ack = ($urandom % 4) != 0;
         tick();
      end
      // flush together with the final push
      valid_write = 1'b1;
      arm_inst = $urandom;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 200 && !(dn_m[0] && dn_m[1]); k++) begin
         valid_write = 1'($urandom % 2);
         arm_inst = $urandom;
         mem_ack = ($urandom % 3) != 0;
         tick();
      end
      check("flush_done", 32'(dn0), 32'h1);
      valid_write = 1'b1;
      repeat (5) tick();
      check("done_ready", 32'(rdy0), 32'h0);
      // reset in the middle of a stall with three words queued
      valid_write = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mem_ack = 1'b0;
      valid_write = 1'b1;
      repeat (3) begin
         arm_inst = $urandom;
         tick();
      end
      valid_write = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_mid_we", 32'(we0), 32'h0);
      check("rst_mid_addr", 32'(addr0), 32'h0);
      check("rst_mid_count", 32'(wc0), 32'h0);
      check("rst_mid_ready", 32'(rdy0), 32'h1);
      reset = 1'b1;
      // ten words then flush: the 3-bit instance exhausts its address space
      writes1 = 0;
      mem_ack = 1'b1;
      valid_write = 1'b1;
      for (int k = 0; k < 10; k++) begin
         arm_inst = $urandom;
         flush = k == 9;
         tick();
      end
      valid_write = 1'b0;
      flush = 1'b0;
      for (int k = 0; k < 50 && !(dn_m[0] && dn_m[1]); k++) tick();
      check("ovf_writes", 32'(writes1), 32'd8);
      check("ovf_flag", 32'(ov1), 32'h1);
      check("ovf_count", 32'(wc1), 32'd8);
      check("ovf_done", 32'(dn1), 32'h1);
      check("big_count", 32'(wc0), 32'd10);
      check("big_done", 32'(dn0), 32'h1);
      check("big_ovf", 32'(ov0), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
